// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit that owns the HI/LO registers.
// It handles MULTU/MULT (shift-add) and DIVU/DIV (restoring shift-subtract).
// An operation takes bit_size iterations plus a sign-fix cycle. done and the
// new HI/LO appear bit_size+1 cycles after start is accepted.
// Optional feature macro: MD_HILO_WRITE_EN adds MTHI/MTLO write ports
// (HI_we, LO_we, Wdata). These ports are honoured only while the unit is idle.
module mult_div_unit #(
    parameter int bit_size = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          MDOp,
    input  logic [bit_size-1:0] src1,
    input  logic [bit_size-1:0] src2,
`ifdef MD_HILO_WRITE_EN
    input  logic                HI_we,
    input  logic                LO_we,
    input  logic [bit_size-1:0] Wdata,
`endif
    output logic                busy,
    output logic                done,
    output logic                DivZero,
    output logic [bit_size-1:0] HI,
    output logic [bit_size-1:0] LO
);

    localparam int CW = $clog2(bit_size + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_cnt;
    logic [bit_size-1:0] r_acc_hi;   // partial product high half / partial remainder
    logic [bit_size-1:0] r_acc_lo;   // multiplier bits / dividend-then-quotient bits
    logic [bit_size-1:0] r_opnd;     // multiplicand or divisor magnitude
    logic [bit_size-1:0] r_raw1;     // unmodified src1, returned in HI on divide-by-zero
    logic [bit_size-1:0] r_hi;
    logic [bit_size-1:0] r_lo;
    logic                r_is_div;
    logic                r_neg_main; // negate product / quotient
    logic                r_neg_rem;  // negate remainder (dividend sign)
    logic                r_zero_div;
    logic                r_busy;
    logic                r_done;
    logic                r_divzero;

    logic                w_accept;
    logic                w_last;
    logic                w_sign1;
    logic                w_sign2;
    logic [bit_size-1:0] w_mag1;
    logic [bit_size-1:0] w_mag2;
    logic [bit_size:0]   w_sum;
    logic [bit_size:0]   w_shift;
    logic [bit_size-1:0] w_diff;
    logic                w_ge;
    logic [bit_size-1:0] w_step_hi;
    logic [bit_size-1:0] w_step_lo;
    logic [2*bit_size-1:0] w_prod;
    logic [2*bit_size-1:0] w_prod_neg;
    logic [bit_size-1:0] w_res_hi;
    logic [bit_size-1:0] w_res_lo;

    // The done cycle is already back in IDLE but still busy, so a start there is refused.
    assign w_accept = (r_state == S_IDLE) && !r_busy && start;
    assign w_last   = (r_cnt == CW'(bit_size - 1));
    assign w_sign1  = MDOp[0] & src1[bit_size-1];
    assign w_sign2  = MDOp[0] & src2[bit_size-1];
    // Magnitudes are unsigned, so the most negative value maps to 2^(bit_size-1).
    assign w_mag1   = w_sign1 ? ({bit_size{1'b0}} - src1) : src1;
    assign w_mag2   = w_sign2 ? ({bit_size{1'b0}} - src2) : src2;

    assign w_sum    = {1'b0, r_acc_hi} + {1'b0, (r_acc_lo[0] ? r_opnd : {bit_size{1'b0}})};
    assign w_shift  = {r_acc_hi, r_acc_lo[bit_size-1]};
    assign w_ge     = (w_shift >= {1'b0, r_opnd});
    // When the subtract succeeds the difference is below the divisor, so the low bits suffice.
    assign w_diff   = w_shift[bit_size-1:0] - r_opnd;

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_neg = {(2*bit_size){1'b0}} - w_prod;

    assign busy    = r_busy;
    assign done    = r_done;
    assign DivZero = r_divzero;
    assign HI      = r_hi;
    assign LO      = r_lo;

    // One shift-add or restoring shift-subtract step on the accumulator pair.
    always_comb begin
        w_step_hi = r_acc_hi;
        w_step_lo = r_acc_lo;
        if (r_is_div) begin
            w_step_hi = w_ge ? w_diff : w_shift[bit_size-1:0];
            w_step_lo = {r_acc_lo[bit_size-2:0], w_ge};
        end else begin
            w_step_hi = w_sum[bit_size:1];
            w_step_lo = {w_sum[0], r_acc_lo[bit_size-1:1]};
        end
    end

    // Final sign correction and divide-by-zero override applied in FIX.
    always_comb begin
        w_res_hi = r_acc_hi;
        w_res_lo = r_acc_lo;
        if (r_zero_div) begin
            w_res_hi = r_raw1;
            w_res_lo = {bit_size{1'b1}};
        end else if (r_is_div) begin
            w_res_lo = r_neg_main ? ({bit_size{1'b0}} - r_acc_lo) : r_acc_lo;
            w_res_hi = r_neg_rem  ? ({bit_size{1'b0}} - r_acc_hi) : r_acc_hi;
        end else begin
            {w_res_hi, w_res_lo} = r_neg_main ? w_prod_neg : w_prod;
        end
    end

    // Next-state logic for IDLE -> RUN (bit_size steps) -> FIX -> IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_RUN : S_IDLE;
            S_RUN:   w_next = w_last ? S_FIX : S_RUN;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand capture, iteration datapath, HI/LO and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= {CW{1'b0}};
            r_acc_hi   <= {bit_size{1'b0}};
            r_acc_lo   <= {bit_size{1'b0}};
            r_opnd     <= {bit_size{1'b0}};
            r_raw1     <= {bit_size{1'b0}};
            r_hi       <= {bit_size{1'b0}};
            r_lo       <= {bit_size{1'b0}};
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_zero_div <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_divzero  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= w_accept;
`ifdef MD_HILO_WRITE_EN
                    if (!r_busy && HI_we) begin
                        r_hi <= Wdata;
                    end
                    if (!r_busy && LO_we) begin
                        r_lo <= Wdata;
                    end
`endif
                    if (w_accept) begin
                        r_cnt      <= {CW{1'b0}};
                        r_is_div   <= MDOp[1];
                        r_neg_main <= w_sign1 ^ w_sign2;
                        r_neg_rem  <= w_sign1;
                        r_zero_div <= MDOp[1] && (src2 == {bit_size{1'b0}});
                        r_raw1     <= src1;
                        r_acc_hi   <= {bit_size{1'b0}};
                        r_acc_lo   <= MDOp[1] ? w_mag1 : w_mag2;
                        r_opnd     <= MDOp[1] ? w_mag2 : w_mag1;
                    end
                end
                S_RUN: begin
                    r_cnt    <= r_cnt + CW'(1);
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                end
                S_FIX: begin
                    r_hi      <= w_res_hi;
                    r_lo      <= w_res_lo;
                    r_done    <= 1'b1;
                    r_divzero <= r_zero_div;
                    r_cnt     <= {CW{1'b0}};
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit (bit_size = 32).
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  MDOp;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic        DivZero;
    logic [31:0] HI;
    logic [31:0] LO;
`ifdef MD_HILO_WRITE_EN
    logic        HI_we;
    logic        LO_we;
    logic [31:0] Wdata;
`endif

    int n_cmp;
    int n_err;

    mult_div_unit #(.bit_size(32)) dut (
        .clk(clk), .rst(rst), .start(start), .MDOp(MDOp), .src1(src1), .src2(src2),
`ifdef MD_HILO_WRITE_EN
        .HI_we(HI_we), .LO_we(LO_we), .Wdata(Wdata),
`endif
        .busy(busy), .done(done), .DivZero(DivZero), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Start one op; optionally re-pulse start at cycle 5 of the busy window.
    // Returns the cycle (after the accept edge) at which done was seen, 0 if never.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit repulse, output int lat);
        lat = 0;
        @(negedge clk);
        start = 1'b1; MDOp = op; src1 = a; src2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            if (repulse && i == 5) begin
                start = 1'b1; MDOp = 2'd0; src1 = 32'd3; src2 = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_latency", 64'(lat), 64'd33);
    endtask

    initial begin
        int lat;
        logic [31:0] keep_hi;
        logic [31:0] keep_lo;
        n_cmp = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; MDOp = 2'd0; src1 = 32'd0; src2 = 32'd0;
`ifdef MD_HILO_WRITE_EN
        HI_we = 1'b0; LO_we = 1'b0; Wdata = 32'd0;
`endif
        //               op     a             b             exp_hi        exp_lo        dz
        vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB, 1'b0};
        vecs[3]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[4]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[5]  = '{2'd0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[6]  = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[8]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[9]  = '{2'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[10] = '{2'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{2'd2, 32'd5,        32'd10,       32'd5,        32'd0,        1'b0};
        vecs[12] = '{2'd2, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0};
        vecs[13] = '{2'd2, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
        vecs[14] = '{2'd3, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_divzero", {63'd0, DivZero}, 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 15; v++) begin
            run_op(vecs[v].op, vecs[v].a, vecs[v].b, 1'b0, lat);
            check($sformatf("v%0d_done", v), {63'd0, done}, 64'd1);
            check($sformatf("v%0d_busy_in_done", v), {63'd0, busy}, 64'd1);
            check($sformatf("v%0d_divzero", v), {63'd0, DivZero}, {63'd0, vecs[v].exp_dz});
            check($sformatf("v%0d_hi", v), {32'd0, HI}, {32'd0, vecs[v].exp_hi});
            check($sformatf("v%0d_lo", v), {32'd0, LO}, {32'd0, vecs[v].exp_lo});
            @(posedge clk); #1;
            check($sformatf("v%0d_done_fell", v), {63'd0, done}, 64'd0);
            check($sformatf("v%0d_busy_fell", v), {63'd0, busy}, 64'd0);
            check($sformatf("v%0d_hilo_hold", v), {HI, LO}, {vecs[v].exp_hi, vecs[v].exp_lo});
        end

        // start re-pulsed mid-op and in the done cycle: both must be ignored.
        run_op(2'd2, 32'd100, 32'd7, 1'b1, lat);
        check("repulse_hi", {32'd0, HI}, 64'd2);
        check("repulse_lo", {32'd0, LO}, 64'd14);
        start = 1'b1; MDOp = 2'd0; src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_cycle_start_busy", {63'd0, busy}, 64'd0);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) lat = i;
        end
        check("repulse_no_extra_op", 64'(lat), 64'd0);
        check("repulse_hilo_unchanged", {HI, LO}, {32'd2, 32'd14});

        // synchronous reset at cycle 10 of a DIVU aborts with no done.
        @(negedge clk);
        start = 1'b1; MDOp = 2'd2; src1 = 32'd1000; src2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) lat = i;
        end
        check("abort_no_done", 64'(lat), 64'd0);

`ifdef MD_HILO_WRITE_EN
        // MTHI in IDLE.
        @(negedge clk);
        HI_we = 1'b1; Wdata = 32'hCAFEBABE;
        @(posedge clk); #1;
        HI_we = 1'b0;
        check("mthi_idle", {32'd0, HI}, {32'd0, 32'hCAFEBABE});
        check("mthi_lo_kept", {32'd0, LO}, 64'd0);
        // Both writes together.
        @(negedge clk);
        HI_we = 1'b1; LO_we = 1'b1; Wdata = 32'h12345678;
        @(posedge clk); #1;
        HI_we = 1'b0; LO_we = 1'b0;
        check("mthi_mtlo_both", {HI, LO}, {32'h12345678, 32'h12345678});
        // Write while busy is ignored; HI only changes at done.
        @(negedge clk);
        start = 1'b1; MDOp = 2'd2; src1 = 32'd100; src2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        HI_we = 1'b1; Wdata = 32'hCAFEBABE;
        @(posedge clk); #1;
        HI_we = 1'b0;
        check("mthi_busy_ignored", {32'd0, HI}, {32'd0, 32'h12345678});
        lat = 0;
        for (int i = 5; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("mthi_busy_latency", 64'(lat), 64'd33);
        check("mthi_busy_result", {HI, LO}, {32'd2, 32'd14});
        @(posedge clk); #1;
        // Write and start in the same IDLE cycle: write lands, op still runs.
        @(negedge clk);
        start = 1'b1; MDOp = 2'd0; src1 = 32'd6; src2 = 32'd7;
        LO_we = 1'b1; Wdata = 32'h0BADF00D;
        @(posedge clk); #1;
        start = 1'b0; LO_we = 1'b0;
        check("write_with_start_lo", {32'd0, LO}, {32'd0, 32'h0BADF00D});
        check("write_with_start_busy", {63'd0, busy}, 64'd1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("write_with_start_latency", 64'(lat), 64'd33);
        check("write_with_start_result", {HI, LO}, {32'd0, 32'd42});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
